// File: rtl/pim_op_sequencer.sv
// pim_op_sequencer: one-command-at-a-time sequencer in front of the PIM array.
// Reads operand A, operand B, computes, writes the result to the destination.
// Optional feature macro: PIM_MUL_EN (adds opcode 101, unsigned multiply).
module pim_op_sequencer #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr_a,
   input  logic [ADDR_W-1:0] cmd_addr_b,
   input  logic [ADDR_W-1:0] cmd_addr_d,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_ready
);

   typedef enum logic [3:0] {
      IDLE, RD_A, WT_A, RD_B, WT_B, EXEC, WR_D, WT_D, DONE
   } state_t;

   typedef struct packed {
      logic [2:0]        op;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] d;
   } cmd_t;

   state_t              state, state_nx;
   cmd_t                cmd_q;
   logic [DATA_W-1:0]   opa_q, opb_q, result_q, alu_res;
   logic                err_q;
   logic [7:0]          wait_cnt;
   logic                in_wt, timeout_hit, accept;

   // Opcode legality depends on whether the multiplier is built.
   function automatic logic op_legal(input logic [2:0] op);
`ifdef PIM_MUL_EN
      return (op <= 3'd5);
`else
      return (op <= 3'd4);
`endif
   endfunction

   assign in_wt       = (state == WT_A) || (state == WT_B) || (state == WT_D);
   // Timeout fires on the cycle the counter would reach TIMEOUT.
   assign timeout_hit = in_wt && !mem_ready && (wait_cnt == 8'(TIMEOUT - 1));
   assign accept      = (state == IDLE) && cmd_valid && !rst;
   assign err         = err_q;
   assign result      = result_q;

   // ALU on captured operands; all arithmetic wraps to DATA_W bits.
   always_comb begin
      alu_res = '0;
      case (cmd_q.op)
         3'd0:    alu_res = opa_q + opb_q;
         3'd1:    alu_res = opa_q - opb_q;
         3'd2:    alu_res = opa_q & opb_q;
         3'd3:    alu_res = opa_q | opb_q;
         3'd4:    alu_res = opa_q ^ opb_q;
`ifdef PIM_MUL_EN
         3'd5:    alu_res = opa_q * opb_q;
`endif
         default: alu_res = '0;
      endcase
   end

   // State register; reset forces IDLE without waiting for a clock edge.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and memory-side outputs, decoded purely from state so that
   // asynchronous reset drives every output low immediately.
   always_comb begin
      state_nx    = state;
      cmd_ready   = 1'b0;
      done        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_data_in = '0;
      case (state)
         IDLE: begin
            cmd_ready = !rst;
            if (accept) state_nx = op_legal(cmd_op) ? RD_A : DONE;
         end
         RD_A: begin
            mem_read    = 1'b1;
            mem_address = cmd_q.a;
            state_nx    = WT_A;
         end
         WT_A: begin
            mem_address = cmd_q.a;
            if (mem_ready)        state_nx = RD_B;
            else if (timeout_hit) state_nx = DONE;
         end
         RD_B: begin
            mem_read    = 1'b1;
            mem_address = cmd_q.b;
            state_nx    = WT_B;
         end
         WT_B: begin
            mem_address = cmd_q.b;
            if (mem_ready)        state_nx = EXEC;
            else if (timeout_hit) state_nx = DONE;
         end
         EXEC: state_nx = WR_D;
         WR_D: begin
            mem_write   = 1'b1;
            mem_address = cmd_q.d;
            mem_data_in = result_q;
            state_nx    = WT_D;
         end
         WT_D: begin
            mem_address = cmd_q.d;
            mem_data_in = result_q;
            if (mem_ready)        state_nx = DONE;
            else if (timeout_hit) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command latch, operand capture, result/err registers and wait counter.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         cmd_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (accept) begin
            cmd_q <= '{op: cmd_op, a: cmd_addr_a, b: cmd_addr_b, d: cmd_addr_d};
            err_q <= !op_legal(cmd_op);
         end
         // Request states precede every wait state, so clearing here
         // clears the counter on entry to WT_*.
         if (state == RD_A || state == RD_B || state == WR_D)
            wait_cnt <= '0;
         else if (in_wt && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout_hit)                   err_q    <= 1'b1;
         if (state == WT_A && mem_ready)    opa_q    <= mem_data_out;
         if (state == WT_B && mem_ready)    opb_q    <= mem_data_out;
         if (state == EXEC)                 result_q <= alu_res;
      end
   end

endmodule
